// File: rtl/axis_packet_generator.sv
// AXI-Stream burst source: a debounced button press emits NUM_PKTS packets of PKT_LEN beats
// carrying {8'hA5, seq, beat}, with fully registered outputs and tready backpressure.
module axis_packet_generator #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned PKT_LEN      = 16,
  parameter int unsigned NUM_PKTS     = 4,
  parameter int unsigned IDLE_GAP     = 2,
  parameter int unsigned DEBOUNCE_CYC = 1000000
) (
  input  logic              clk,
  input  logic              resentn,
  input  logic              start_btn,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  input  logic              m_tready,
  output logic              busy,
  output logic [7:0]        pkt_sent
);

  localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned GAP_W = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
  localparam int unsigned PIB_W = $clog2(NUM_PKTS + 1);

  localparam logic [DB_W-1:0]  DB_MAX      = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_MAX     = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
  localparam logic [PIB_W-1:0] PIB_LAST    = PIB_W'(NUM_PKTS - 1);
  localparam logic [15:0]      BEAT_LAST   = 16'(PKT_LEN - 1);
  localparam logic             SINGLE_BEAT = (PKT_LEN == 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  function automatic logic [DATA_W-1:0] pattern(input logic [7:0] s, input logic [15:0] b);
    return DATA_W'({8'hA5, s, b});
  endfunction

  // Button conditioning
  logic [1:0]      r_sync;
  logic            r_db_last;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_db_level;
  logic            r_armed;
  logic            r_start;
  logic            w_sync;
  logic            w_db_stable;

  assign w_sync      = r_sync[1];
  assign w_db_stable = (r_db_cnt == DB_MAX);

  // Sync/last reset high so a button held through reset never looks like a fresh press;
  // r_armed requires a confirmed released level before the first start is honoured.
  always_ff @(posedge clk or negedge resentn) begin
    if (!resentn) begin
      r_sync     <= 2'b11;
      r_db_last  <= 1'b1;
      r_db_cnt   <= '0;
      r_db_level <= 1'b0;
      r_armed    <= 1'b0;
      r_start    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], start_btn};
      r_db_last <= w_sync;
      if (w_sync != r_db_last) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt != DB_MAX) begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
      r_start <= 1'b0;
      if (w_db_stable) begin
        r_db_level <= r_db_last;
        if (!r_db_last) begin
          r_armed <= 1'b1;
        end
        r_start <= r_db_last && !r_db_level && r_armed;
      end
    end
  end

  // Packet FSM
  state_t             r_state, w_state_nxt;
  logic [15:0]        r_beat, w_beat_nxt;
  logic [7:0]         r_seq, w_seq_nxt;
  logic [7:0]         r_pkt_sent, w_pkt_sent_nxt;
  logic [PIB_W-1:0]   r_pkt_in_burst, w_pkt_in_burst_nxt;
  logic [GAP_W-1:0]   r_gap, w_gap_nxt;
  logic               r_tvalid, w_tvalid_nxt;
  logic               r_tlast, w_tlast_nxt;
  logic [DATA_W-1:0]  r_tdata, w_tdata_nxt;
  logic               r_busy, w_busy_nxt;
  logic               w_accept;

  assign w_accept = r_tvalid && m_tready;

  always_ff @(posedge clk or negedge resentn) begin
    if (!resentn) begin
      r_state        <= S_IDLE;
      r_beat         <= '0;
      r_seq          <= '0;
      r_pkt_sent     <= '0;
      r_pkt_in_burst <= '0;
      r_gap          <= '0;
      r_tvalid       <= 1'b0;
      r_tlast        <= 1'b0;
      r_tdata        <= '0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_beat         <= w_beat_nxt;
      r_seq          <= w_seq_nxt;
      r_pkt_sent     <= w_pkt_sent_nxt;
      r_pkt_in_burst <= w_pkt_in_burst_nxt;
      r_gap          <= w_gap_nxt;
      r_tvalid       <= w_tvalid_nxt;
      r_tlast        <= w_tlast_nxt;
      r_tdata        <= w_tdata_nxt;
      r_busy         <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_beat_nxt         = r_beat;
    w_seq_nxt          = r_seq;
    w_pkt_sent_nxt     = r_pkt_sent;
    w_pkt_in_burst_nxt = r_pkt_in_burst;
    w_gap_nxt          = r_gap;
    w_tvalid_nxt       = r_tvalid;
    w_tlast_nxt        = r_tlast;
    w_tdata_nxt        = r_tdata;
    w_busy_nxt         = r_busy;

    case (r_state)
      S_IDLE: begin
        if (r_start) begin
          w_state_nxt        = S_SEND;
          w_tvalid_nxt       = 1'b1;
          w_busy_nxt         = 1'b1;
          w_pkt_in_burst_nxt = '0;
          w_beat_nxt         = '0;
          w_tlast_nxt        = SINGLE_BEAT;
          w_tdata_nxt        = pattern(r_seq, 16'd0);
        end
      end

      S_SEND: begin
        if (w_accept) begin
          if (r_beat == BEAT_LAST) begin
            w_beat_nxt         = '0;
            w_seq_nxt          = r_seq + 8'd1;
            w_pkt_sent_nxt     = r_pkt_sent + 8'd1;
            w_pkt_in_burst_nxt = r_pkt_in_burst + PIB_W'(1);
            if (r_pkt_in_burst == PIB_LAST) begin
              w_state_nxt  = S_IDLE;
              w_tvalid_nxt = 1'b0;
              w_tlast_nxt  = 1'b0;
              w_busy_nxt   = 1'b0;
            end else if (IDLE_GAP == 0) begin
              w_tlast_nxt = SINGLE_BEAT;
              w_tdata_nxt = pattern(r_seq + 8'd1, 16'd0);
            end else begin
              w_state_nxt  = S_GAP;
              w_gap_nxt    = '0;
              w_tvalid_nxt = 1'b0;
              w_tlast_nxt  = 1'b0;
            end
          end else begin
            w_beat_nxt  = r_beat + 16'd1;
            w_tlast_nxt = (w_beat_nxt == BEAT_LAST);
            w_tdata_nxt = pattern(r_seq, w_beat_nxt);
          end
        end
      end

      S_GAP: begin
        if (r_gap == GAP_MAX) begin
          w_state_nxt  = S_SEND;
          w_tvalid_nxt = 1'b1;
          w_tlast_nxt  = SINGLE_BEAT;
          w_tdata_nxt  = pattern(r_seq, 16'd0);
        end else begin
          w_gap_nxt = r_gap + GAP_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign m_tdata  = r_tdata;
  assign m_tvalid = r_tvalid;
  assign m_tlast  = r_tlast;
  assign busy     = r_busy;
  assign pkt_sent = r_pkt_sent;

endmodule
